// File: rtl/key_expansion_128.sv
// Iterative AES-128 key schedule: one round key per clock, all 11 keys held
// on a flat registered bus for the downstream round pipeline.
module key_expansion_128 #(
  parameter int BLOCK_LENGTH = 128,
  parameter int NUM_ROUNDS   = 10
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   START,
  input  logic [BLOCK_LENGTH-1:0]                KEY_IN,
  output logic                                   BUSY,
  output logic                                   KEYS_VALID,
  output logic [BLOCK_LENGTH*(NUM_ROUNDS+1)-1:0] ROUND_KEYS
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              step_q, step_d;
  logic [7:0]              rcon_q, rcon_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic [BLOCK_LENGTH-1:0] last_q, last_d;
  logic [BLOCK_LENGTH-1:0] rk_q [0:NUM_ROUNDS];
  logic [BLOCK_LENGTH-1:0] rk_d [0:NUM_ROUNDS];
  logic [BLOCK_LENGTH-1:0] next_rk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Forward S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  logic [31:0] w0, w1, w2, w3, rot_w, sub_w, t_w, n0, n1, n2, n3;

  always_comb begin
    w0    = last_q[127:96];
    w1    = last_q[95:64];
    w2    = last_q[63:32];
    w3    = last_q[31:0];
    rot_w = {w3[23:0], w3[31:24]};
    sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    t_w   = sub_w ^ {rcon_q, 24'h000000};
    n0    = w0 ^ t_w;
    n1    = w1 ^ n0;
    n2    = w2 ^ n1;
    n3    = w3 ^ n2;
    next_rk = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    last_d  = last_q;
    for (int k = 0; k <= NUM_ROUNDS; k++) rk_d[k] = rk_q[k];

    case (state_q)
      IDLE, DONE: begin
        if (START) begin
          rk_d[0] = KEY_IN;
          last_d  = KEY_IN;
          step_d  = 4'd1;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        for (int k = 1; k <= NUM_ROUNDS; k++) begin
          if (step_q == 4'(k)) rk_d[k] = next_rk;
        end
        last_d = next_rk;
        rcon_d = xtime(rcon_q);
        if (step_q == 4'(NUM_ROUNDS)) begin
          step_d  = 4'd0;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= '0;
      for (int k = 0; k <= NUM_ROUNDS; k++) rk_q[k] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int k = 0; k <= NUM_ROUNDS; k++) rk_q[k] <= rk_d[k];
    end
  end

  for (genvar g = 0; g <= NUM_ROUNDS; g++) begin : g_out
    assign ROUND_KEYS[BLOCK_LENGTH*g +: BLOCK_LENGTH] = rk_q[g];
  end

  assign BUSY       = busy_q;
  assign KEYS_VALID = valid_q;

endmodule

// File: doc/key_expansion_128.md
Name: key_expansion_128

Overview:
- Iterative AES-128 key schedule. It sits directly upstream of the pipelined encryption rounds and supplies their KEY inputs.
- Expands one 128-bit cipher key into 11 round keys (RK0..RK10), one new round key per clock.
- Holds all 11 round keys on a flat bus, so every pipeline stage sees its key simultaneously and statically.
- Uses a start/busy/valid handshake toward the controller that loads the key.

Parameters:
- BLOCK_LENGTH, 128: key/round-key width; only 128 is supported.
- NUM_ROUNDS, 10: number of expansion steps; only 10 is supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- START  input  1  request expansion of KEY_IN; single-cycle pulse or level.
- KEY_IN  input  128  cipher key; bits [127:120] are byte 0 (FIPS-197 order).
- BUSY  output  1  expansion in progress.
- KEYS_VALID  output  1  all 11 round keys are valid and stable.
- ROUND_KEYS  output  1408  RKk occupies bits [128*k+127 : 128*k], k = 0..10.

Behaviour:
- Reset: when rst=0 at a clock edge, all of the following are cleared:
  - ROUND_KEYS=0, BUSY=0, KEYS_VALID=0.
  - Step counter=0, rcon=8'h01.
  - State=IDLE.
- Reset mid-expansion aborts the expansion immediately; partial keys are discarded (zeroed).
- States: IDLE, EXPAND, DONE. State and all outputs are registered.
- IDLE/DONE with START=1 at edge E0:
  - RK0 <= KEY_IN.
  - All other RKs are left unchanged.
  - Step counter <= 1, rcon <= 8'h01.
  - BUSY <= 1, KEYS_VALID <= 0.
  - State <= EXPAND.
- EXPAND, at edge Ei (i = 1..10): RKi <= f(RK(i-1), rcon), then rcon <= xtime(rcon).
  - xtime: rcon<<1, XOR 8'h1B if rcon[7] was 1.
  - Required rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- f(), with words w0=RK[127:96], w1=RK[95:64], w2=RK[63:32], w3=RK[31:0]:
  - t = SubWord(RotWord(w3)) XOR {rcon,24'h0}; RotWord = {w3[23:0], w3[31:24]}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- SubWord is four AES forward S-box lookups. The existing sub_bytes block may be instantiated with the word in any 32-bit lane and the unused lanes ignored.
- At E10: state <= DONE, BUSY <= 0, KEYS_VALID <= 1.
  - BUSY is high for exactly 10 cycles (E0 to E10).
  - KEYS_VALID is high from E10 onward.
- START while BUSY=1 is ignored; KEY_IN is not re-sampled.
- START in DONE restarts expansion:
  - KEYS_VALID falls at the same edge.
  - Consumers must not use ROUND_KEYS while KEYS_VALID=0.
- DONE holds ROUND_KEYS constant indefinitely while START=0.
- START and rst=0 at the same edge: reset wins.
- KEY_IN only needs to be stable at the START edge.
- No combinational path from inputs to outputs.

Test Plan:
- FIPS-197 key: KEY_IN=2b7e151628aed2a6abf7158809cf4f3c, 1-cycle START.
  - RK1=a0fafe1788542cb123a339392a6c7605.
  - RK10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - BUSY high for exactly 10 cycles; KEYS_VALID rises at E10.
- Key 000102030405060708090a0b0c0d0e0f:
  - RK10=13111d7fe3944a17f307a78b4d2b30c5.
  - RK0 equals KEY_IN.
- All-zero key:
  - RK1=62636363626363636263636362636363.
  - RK10=b4ef5bcb3e92e21123e951cf6f8f188e.
- START held high throughout and a changed KEY_IN applied at E3:
  - Result equals the first key's schedule.
  - After DONE, the held START triggers a new expansion, and KEYS_VALID drops for 10 cycles.
- rst=0 asserted at E5:
  - Next edge: ROUND_KEYS=0, BUSY=0, KEYS_VALID=0.
  - A fresh START afterwards yields a correct full schedule, with rcon restarting at 01.
- Restart from DONE with a new key: KEYS_VALID=0 for E0..E9, then all 11 keys match the new key's schedule.
